serial_adder_sub: RTL and testbench

Parametrised, multi-cycle, digit-serial adder/subtractor built from a single DIGIT-bit full-adder slice and a carry flip-flop. It trades latency for area in arithmetic datapaths where a full-width ripple adder is too large. Operands are captured on a start pulse and processed LSB-first, DIGIT bits per clock. The registered sum, carry-out and signed overflow are presented with a one-cycle done strobe.

---
 rtl/serial_adder_sub.sv | 122 ++++++++++++
 tb/tb_serial_adder_sub.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_sub.sv
// Digit-serial adder/subtractor: one DIGIT-bit adder slice plus a carry flop,
// processing captured operands LSB-first and presenting sum/cout/ovf with a done strobe.
module serial_adder_sub #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NDIG  = WIDTH / DIGIT;
   localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] op_a_q, op_a_d;
   logic [WIDTH-1:0] op_b_q, op_b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             done_q, done_d;

   logic [DIGIT:0]   slice;
   logic [DIGIT-1:0] dig;
   logic             msb_cin;

   // The carry into the slice MSB is recovered from its sum bit: s = a ^ b ^ c_in.
   always_comb begin
      slice   = {1'b0, op_a_q[DIGIT-1:0]} + {1'b0, op_b_q[DIGIT-1:0]}
              + {{DIGIT{1'b0}}, carry_q};
      dig     = slice[DIGIT-1:0];
      msb_cin = op_a_q[DIGIT-1] ^ op_b_q[DIGIT-1] ^ dig[DIGIT-1];
   end

   // NOTE: every variable gets its hold value first so no path through the case infers a latch.
   always_comb begin
      state_d = state_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      res_d   = res_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               op_a_d  = a;
               op_b_d  = sub ? ~b : b;
               carry_d = cin ^ sub;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            op_a_d  = op_a_q >> DIGIT;
            op_b_d  = op_b_q >> DIGIT;
            carry_d = slice[DIGIT];
            res_d   = (res_q >> DIGIT) | (WIDTH'(dig) << (WIDTH - DIGIT));
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(NDIG - 1)) begin
               sum_d   = res_d;
               cout_d  = slice[DIGIT];
               ovf_d   = msb_cin ^ slice[DIGIT];
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         op_a_q  <= '0;
         op_b_q  <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_sub.sv
// Bench for serial_adder_sub: five parameterisations share one stimulus stream and
// are checked against hand values and a width-aware arithmetic model.
module tb_serial_adder_sub;

   localparam int NDUT = 5;
   localparam int W  [NDUT] = '{8, 8, 8, 16, 12};
   localparam int ND [NDUT] = '{8, 4, 2, 4, 1};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        sub = 1'b0;
   logic        cin = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;

   logic [NDUT-1:0] busy_v, done_v, cout_v, ovf_v;
   logic [7:0]  s0, s1, s2;
   logic [15:0] s3;
   logic [11:0] s4;
   logic [15:0] sum_v    [NDUT];
   logic [15:0] prev_sum [NDUT];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   serial_adder_sub #(.WIDTH(8), .DIGIT(1)) u_d0 (.clk(clk), .rst(rst), .start(start), .sub(sub),
      .a(a[7:0]), .b(b[7:0]), .cin(cin), .busy(busy_v[0]), .done(done_v[0]), .sum(s0),
      .cout(cout_v[0]), .ovf(ovf_v[0]));
   serial_adder_sub #(.WIDTH(8), .DIGIT(2)) u_d1 (.clk(clk), .rst(rst), .start(start), .sub(sub),
      .a(a[7:0]), .b(b[7:0]), .cin(cin), .busy(busy_v[1]), .done(done_v[1]), .sum(s1),
      .cout(cout_v[1]), .ovf(ovf_v[1]));
   serial_adder_sub #(.WIDTH(8), .DIGIT(4)) u_d2 (.clk(clk), .rst(rst), .start(start), .sub(sub),
      .a(a[7:0]), .b(b[7:0]), .cin(cin), .busy(busy_v[2]), .done(done_v[2]), .sum(s2),
      .cout(cout_v[2]), .ovf(ovf_v[2]));
   serial_adder_sub #(.WIDTH(16), .DIGIT(4)) u_d3 (.clk(clk), .rst(rst), .start(start), .sub(sub),
      .a(a), .b(b), .cin(cin), .busy(busy_v[3]), .done(done_v[3]), .sum(s3),
      .cout(cout_v[3]), .ovf(ovf_v[3]));
   serial_adder_sub #(.WIDTH(12), .DIGIT(12)) u_d4 (.clk(clk), .rst(rst), .start(start), .sub(sub),
      .a(a[11:0]), .b(b[11:0]), .cin(cin), .busy(busy_v[4]), .done(done_v[4]), .sum(s4),
      .cout(cout_v[4]), .ovf(ovf_v[4]));

   assign sum_v[0] = {8'h00, s0};
   assign sum_v[1] = {8'h00, s1};
   assign sum_v[2] = {8'h00, s2};
   assign sum_v[3] = s3;
   assign sum_v[4] = {4'h0, s4};

   // Returns {ovf, cout, sum}; overflow from operand/result signs.
   function automatic logic [17:0] model(input int w, input logic [15:0] x, input logic [15:0] y,
                                         input logic s, input logic c);
      logic [16:0] m, xa, yb, full;
      logic        ov;
      m    = (17'd1 << w) - 17'd1;
      xa   = {1'b0, x} & m;
      yb   = (s ? ~{1'b0, y} : {1'b0, y}) & m;
      full = xa + yb + {16'd0, c ^ s};
      ov   = (xa[w-1] == yb[w-1]) && (full[w-1] != xa[w-1]);
      return {ov, full[w], full[15:0] & m[15:0]};
   endfunction

   task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts,
                         input logic tc, input bit scramble);
      int bc [NDUT];
      int dc [NDUT];
      int dat[NDUT];
      logic [17:0] exp_v[NDUT];
      for (int i = 0; i < NDUT; i++) begin
         bc[i] = 0; dc[i] = 0; dat[i] = 0;
         exp_v[i] = model(W[i], ta, tb_v, ts, tc);
      end
      @(negedge clk);
      a = ta; b = tb_v; sub = ts; cin = tc; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         for (int i = 0; i < NDUT; i++) begin
            if (busy_v[i]) begin
               bc[i]++;
               checks++;
               if (sum_v[i] !== prev_sum[i]) begin
                  errors++;
                  $display("FAIL hold dut%0d cyc%0d: sum=%h expected %h", i, cyc, sum_v[i], prev_sum[i]);
               end
            end
            if (done_v[i]) begin
               dc[i]++;
               dat[i] = cyc;
               checks++;
               if ({ovf_v[i], cout_v[i], sum_v[i]} !== exp_v[i]) begin
                  errors++;
                  $display("FAIL result dut%0d a=%h b=%h sub=%0b cin=%0b: ovf/cout/sum=%0b/%0b/%h expected %0b/%0b/%h",
                           i, ta, tb_v, ts, tc, ovf_v[i], cout_v[i], sum_v[i],
                           exp_v[i][17], exp_v[i][16], exp_v[i][15:0]);
               end
            end
         end
         if (scramble) begin
            a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
         end
         @(negedge clk);
      end
      for (int i = 0; i < NDUT; i++) begin
         checks++;
         if (bc[i] != ND[i] || dc[i] != 1 || dat[i] != ND[i] + 1) begin
            errors++;
            $display("FAIL timing dut%0d: busy=%0d done=%0d at %0d expected busy=%0d done=1 at %0d",
                     i, bc[i], dc[i], dat[i], ND[i], ND[i] + 1);
         end
         prev_sum[i] = exp_v[i][15:0];
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < NDUT; i++) begin
         checks++;
         if (busy_v[i] !== 1'b0 || done_v[i] !== 1'b0 || sum_v[i] !== 16'h0 ||
             cout_v[i] !== 1'b0 || ovf_v[i] !== 1'b0) begin
            errors++;
            $display("FAIL reset dut%0d: busy/done/cout/ovf=%0b%0b%0b%0b sum=%h expected 0000 sum=0",
                     i, busy_v[i], done_v[i], cout_v[i], ovf_v[i], sum_v[i]);
         end
         prev_sum[i] = 16'h0;
      end
      rst = 1'b0;
   endtask

   task automatic test_add();
      run_op(16'h003C, 16'h005A, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({ovf_v[0], cout_v[0], sum_v[0]} !== {1'b1, 1'b0, 16'h0096}) begin
         errors++;
         $display("FAIL add: ovf/cout/sum=%0b/%0b/%h expected 1/0/0096", ovf_v[0], cout_v[0], sum_v[0]);
      end
   endtask

   task automatic test_sub();
      run_op(16'h0010, 16'h0020, 1'b1, 1'b1, 1'b1);
      checks++;
      if ({ovf_v[0], cout_v[0], sum_v[0]} !== {1'b0, 1'b0, 16'h00EF}) begin
         errors++;
         $display("FAIL sub_borrow: ovf/cout/sum=%0b/%0b/%h expected 0/0/00ef", ovf_v[0], cout_v[0], sum_v[0]);
      end
   endtask

   task automatic test_wrap();
      run_op(16'h00FF, 16'h0001, 1'b0, 1'b1, 1'b0);
      checks++;
      if ({ovf_v[2], cout_v[2], sum_v[2]} !== {1'b0, 1'b1, 16'h0001}) begin
         errors++;
         $display("FAIL wrap: ovf/cout/sum=%0b/%0b/%h expected 0/1/0001", ovf_v[2], cout_v[2], sum_v[2]);
      end
      run_op(16'h007F, 16'h0001, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({ovf_v[2], sum_v[2]} !== {1'b1, 16'h0080}) begin
         errors++;
         $display("FAIL wrap_ovf: ovf/sum=%0b/%h expected 1/0080", ovf_v[2], sum_v[2]);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 1000; n++)
         run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      a = 16'h0077; b = 16'h0011; sub = 1'b0; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (busy_v[0] !== 1'b1) begin
         errors++;
         $display("FAIL mid_busy: busy=%0b expected 1", busy_v[0]);
      end
      rst = 1'b1;
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) begin
         checks++;
         if (busy_v[i] !== 1'b0 || done_v[i] !== 1'b0 || sum_v[i] !== 16'h0 ||
             cout_v[i] !== 1'b0 || ovf_v[i] !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset dut%0d: busy/done/cout/ovf=%0b%0b%0b%0b sum=%h expected 0000 sum=0",
                     i, busy_v[i], done_v[i], cout_v[i], ovf_v[i], sum_v[i]);
         end
         prev_sum[i] = 16'h0;
      end
      rst = 1'b0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(negedge clk);
         checks++;
         if (done_v !== '0 || busy_v !== '0) begin
            errors++;
            $display("FAIL aborted_done cyc%0d: done=%b busy=%b expected 0", cyc, done_v, busy_v);
         end
      end
      run_op(16'h1234, 16'h0F0F, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_sum;
      logic        exp_busy;
      @(negedge clk);
      a = 16'h0001; b = 16'h0002; sub = 1'b0; cin = 1'b0; start = 1'b1;
      for (int cyc = 1; cyc <= 18; cyc++) begin
         @(negedge clk);
         exp_busy = (cyc != 9) && (cyc != 18);
         exp_sum  = (cyc < 9) ? prev_sum[0] : (cyc < 18) ? 16'h0003 : 16'h000B;
         checks++;
         if (busy_v[0] !== exp_busy || done_v[0] !== !exp_busy || sum_v[0] !== exp_sum) begin
            errors++;
            $display("FAIL b2b cyc%0d: busy=%0b done=%0b sum=%h expected busy=%0b done=%0b sum=%h",
                     cyc, busy_v[0], done_v[0], sum_v[0], exp_busy, !exp_busy, exp_sum);
         end
         if (cyc < 9) begin
            a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
         end else if (cyc == 9) begin
            a = 16'h0005; b = 16'h0006; sub = 1'b0; cin = 1'b0;
         end else begin
            start = 1'b0;
         end
      end
      // Other instances restarted while start was held; bring everything back to a known state.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < NDUT; i++) prev_sum[i] = 16'h0;
      run_op(16'h00A5, 16'h005A, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_wrap();
      test_random();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
